// File: rtl/mm_core.sv
// Register file (32x32, two combinational read ports, one write port) and a
// 64x32 word-addressed data memory that stores port-A read data.
module mm_core (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  R_Addr_A,
  input  logic [4:0]  R_Addr_B,
  input  logic [4:0]  W_Addr,
  input  logic [31:0] W_Data,
  input  logic        Write_reg,
  output logic [31:0] R_Data_A,
  output logic [31:0] R_Data_B,
  input  logic        wea,
  input  logic [5:0]  addr,
  output logic [31:0] douta
);

  logic [31:0] regs_r [0:31];
  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [31:0] mem_r [0:63] = '{default: 32'h0000_0000};
  logic [31:0] douta_r;
  logic [31:0] r_data_a_s;
  logic [31:0] r_data_b_s;
  logic        reg_we_s;
  logic        mem_we_s;

  assign reg_we_s = Reset && Write_reg && (W_Addr != 5'd0);
  assign mem_we_s = Reset && wea;

  // Read port A; register 0 is hard-wired to zero.
  always_comb begin
    r_data_a_s = 32'h0000_0000;
    if (R_Addr_A != 5'd0) begin
      r_data_a_s = regs_r[R_Addr_A];
    end else begin
      r_data_a_s = 32'h0000_0000;
    end
  end

  // Read port B; register 0 is hard-wired to zero.
  always_comb begin
    r_data_b_s = 32'h0000_0000;
    if (R_Addr_B != 5'd0) begin
      r_data_b_s = regs_r[R_Addr_B];
    end else begin
      r_data_b_s = 32'h0000_0000;
    end
  end

  // Register file update: synchronous clear, otherwise single write port.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (reg_we_s) begin
      regs_r[W_Addr] <= W_Data;
    end
  end

  // Memory array write; stores the pre-edge port-A value.
  always_ff @(posedge Clk) begin
    if (mem_we_s) begin
      mem_r[addr] <= r_data_a_s;
    end
  end

  // Registered read port, write-first on a store edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      douta_r <= 32'h0000_0000;
    end else if (wea) begin
      douta_r <= r_data_a_s;
    end else begin
      douta_r <= mem_r[addr];
    end
  end

  assign R_Data_A = r_data_a_s;
  assign R_Data_B = r_data_b_s;
  assign douta    = douta_r;

endmodule

// File: tb/tb_mm_core.sv
// Self-checking bench for mm_core: scoreboard of expected douta values plus
// direct checks of the combinational register read ports.
module tb_mm_core;

  logic        Clk;
  logic        Reset;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_reg;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;
  logic        wea;
  logic [5:0]  addr;
  logic [31:0] douta;

  int n_compared;
  int n_mismatched;

  logic [31:0] model_regs [0:31];
  logic [31:0] model_mem  [0:63];
  logic [31:0] exp_q [$];

  mm_core dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .Write_reg (Write_reg),
    .R_Data_A  (R_Data_A),
    .R_Data_B  (R_Data_B),
    .wea       (wea),
    .addr      (addr),
    .douta     (douta)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0000_0000;
    return model_regs[a];
  endfunction

  // One clock edge: predict from current inputs, push, advance, pop and compare.
  task automatic step(input string tag);
    logic [31:0] exp;
    logic [31:0] ra;
    ra = model_read(R_Addr_A);
    if (!Reset) begin
      exp = 32'h0000_0000;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0000_0000;
    end else begin
      if (wea) begin
        model_mem[addr] = ra;
        exp = ra;
      end else begin
        exp = model_mem[addr];
      end
      if (Write_reg && W_Addr != 5'd0) model_regs[W_Addr] = W_Data;
    end
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    check_eq(tag, douta, exp_q.pop_front());
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
    R_Addr_A = a;
    R_Addr_B = b;
    #1;
    check_eq({tag, "_a"}, R_Data_A, model_read(a));
    check_eq({tag, "_b"}, R_Data_B, model_read(b));
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0000_0000;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0000_0000;
    Reset = 1'b0; R_Addr_A = 5'd0; R_Addr_B = 5'd0; W_Addr = 5'd0;
    W_Data = 32'h0; Write_reg = 1'b0; wea = 1'b0; addr = 6'd0;

    // Reset held for two edges
    #2;
    step("rst_douta0");
    step("rst_douta1");
    Reset = 1'b1;
    R_Addr_A = 5'd0; R_Addr_B = 5'd1; #1;
    check_eq("rst_ra0", R_Data_A, 32'h0);
    check_eq("rst_rb1", R_Data_B, 32'h0);
    R_Addr_A = 5'd31; R_Addr_B = 5'd31; #1;
    check_eq("rst_ra31", R_Data_A, 32'h0);
    check_eq("rst_rb31", R_Data_B, 32'h0);
    check_eq("rst_douta", douta, 32'h0);

    // Register write with no bypass before the edge
    W_Addr = 5'd27; W_Data = 32'hFFC7_FF6F; Write_reg = 1'b1;
    R_Addr_A = 5'd27; R_Addr_B = 5'd0; #1;
    check_eq("no_bypass", R_Data_A, 32'h0);
    step("wr27_edge");
    Write_reg = 1'b0; #1;
    check_eq("rd27", R_Data_A, 32'hFFC7_FF6F);
    check_eq("rd0_b", R_Data_B, 32'h0);

    // Register 0 protection
    W_Addr = 5'd0; W_Data = 32'h1234_5678; Write_reg = 1'b1;
    step("wr0_edge");
    Write_reg = 1'b0;
    R_Addr_A = 5'd0; #1;
    check_eq("reg0_zero", R_Data_A, 32'h0);

    // Store / load
    R_Addr_A = 5'd27; wea = 1'b1; addr = 6'd13;
    step("store13");
    check_eq("store13_const", douta, 32'hFFC7_FF6F);
    wea = 1'b0; addr = 6'd12;
    step("load12");
    check_eq("load12_const", douta, 32'h0);
    addr = 6'd13;
    step("load13");
    check_eq("load13_const", douta, 32'hFFC7_FF6F);

    // Enables off
    Write_reg = 1'b0; W_Addr = 5'd5; W_Data = 32'hAAAA_AAAA;
    R_Addr_A = 5'd27; wea = 1'b0; addr = 6'd20;
    for (int i = 0; i < 3; i++) step("we_off");
    check_eq("mem20_const", douta, 32'h0);
    R_Addr_A = 5'd5; #1;
    check_eq("reg5_zero", R_Data_A, 32'h0);

    // Simultaneous register and memory write stores the old register value
    R_Addr_A = 5'd27; W_Addr = 5'd27; W_Data = 32'h1357_2468;
    Write_reg = 1'b1; wea = 1'b1; addr = 6'd40;
    step("dual_wr");
    Write_reg = 1'b0; wea = 1'b0;
    step("load40");
    check_eq("load40_const", douta, 32'hFFC7_FF6F);
    check_eq("reg27_new", R_Data_A, 32'h1357_2468);

    // Reset discards writes and keeps memory
    Reset = 1'b0; Write_reg = 1'b1; W_Addr = 5'd3; W_Data = 32'hDEAD_BEEF;
    wea = 1'b1; addr = 6'd13; R_Addr_A = 5'd27;
    step("rst_mid");
    Reset = 1'b1; Write_reg = 1'b0; wea = 1'b0;
    read_check("post_rst", 5'd27, 5'd3);
    check_eq("post_rst_27", R_Data_A, 32'h0);
    addr = 6'd13;
    step("rst_keep13");
    check_eq("rst_keep13_const", douta, 32'hFFC7_FF6F);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      Reset     = ($urandom_range(0, 31) != 0);
      Write_reg = $urandom_range(0, 1);
      W_Addr    = $urandom_range(0, 31);
      W_Data    = $urandom;
      wea       = ($urandom_range(0, 3) == 0);
      addr      = $urandom_range(0, 63);
      R_Addr_A  = $urandom_range(0, 31);
      R_Addr_B  = $urandom_range(0, 31);
      #1;
      check_eq("rnd_pre_a", R_Data_A, model_read(R_Addr_A));
      step("rnd_douta");
      read_check("rnd_rd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mm_core.md
# mm_core

Combined register-file and data-memory datapath block for the single-cycle CPU lab datapath. It holds a 32×32-bit general-purpose register file with two combinational read ports and one synchronous write port, plus a 64×32-bit word-addressed data memory. The memory is written with register-file port-A data and read synchronously. It sits between instruction decode (register addresses) and the memory stage (load/store word address).

## Interface
Parameters: none. Widths are fixed.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
- R_Addr_A  input  5  register-file read address, port A.
- R_Addr_B  input  5  register-file read address, port B.
- W_Addr  input  5  register-file write address.
- W_Data  input  32  register-file write data.
- Write_reg  input  1  register-file write enable, active-high.
- R_Data_A  output  32  register[R_Addr_A], combinational.
- R_Data_B  output  32  register[R_Addr_B], combinational.
- wea  input  1  data-memory write enable, active-high.
- addr  input  6 (bits [7:2])  data-memory word address; byte address bits [1:0] are not present.
- douta  output  32  data-memory read data, registered.

## Operation
- Register file: 32 registers x 32 bits.
  - Register 0 always reads 0x00000000.
  - Writes to register 0 are ignored.
- Register write: on a Clk rising edge with Reset=1 and Write_reg=1, register[W_Addr] takes W_Data. With Write_reg=0, no register changes.
- Register read: R_Data_A and R_Data_B follow the addresses and register contents combinationally.
  - There is no write-to-read bypass. Same-address read and write in the same cycle shows the old value until the edge.
- Data memory: 64 words x 32 bits, indexed by addr[7:2]. Write data is R_Data_A; there is no separate memory data-in port.
  - On a rising edge with wea=1, mem[addr] takes R_Data_A.
  - The memory is write-first: on a write edge, douta takes the newly written value.
  - On a rising edge with wea=0, douta takes mem[addr].
- Reset (Reset=0 at a rising edge):
  - All 32 registers become 0 and douta becomes 0.
  - Register writes and memory writes are suppressed during that edge.
  - Memory contents are not cleared.
- Memory initial contents are all zero at configuration/simulation start.
- Independence: register write and memory write may occur on the same edge.
  - The memory stores R_Data_A as it was before the edge, i.e. the pre-write register value.

## Timing
- Register write latency: 1 edge. The new value appears on R_Data_A/B combinationally right after the edge.
- Register read latency: 0 cycles (combinational).
- Memory read latency: 1 edge. douta reflects the addr sampled at the previous rising edge.
- Memory write: 1 edge; douta shows the written data after that same edge.
- Reset is synchronous. Asserting Reset between edges has no effect until the next rising edge.
- Reset values:
  - R_Data_A = R_Data_B = 0 for every address.
  - douta = 0.
- Reset mid-operation: a simultaneous Write_reg or wea at the reset edge is discarded.
- addr wraps naturally within 0..63. There are no out-of-range conditions.

## Test plan
- Reset: hold Reset=0 for 2 edges, then release. Required: R_Data_A = R_Data_B = 0 for addresses 0, 1, 31, and douta = 0.
- Register write/read: W_Addr=27, W_Data=0xFFC7FF6F, Write_reg=1, one edge, then Write_reg=0.
  - R_Addr_A=27 must give R_Data_A=0xFFC7FF6F.
  - R_Addr_B=0 must give R_Data_B=0.
  - Before the edge, R_Addr_A=27 must still show 0.
- Register 0 protection: W_Addr=0, W_Data=0x12345678, Write_reg=1, one edge. R_Data_A at address 0 must remain 0.
- Memory store/load:
  - With reg27=0xFFC7FF6F and R_Addr_A=27, set wea=1, addr=13, one edge. douta must be 0xFFC7FF6F right after that edge.
  - Then set wea=0, addr=12, one edge: douta=0.
  - Then addr=13, one edge: douta=0xFFC7FF6F.
- Write enable off: Write_reg=0, W_Addr=5, W_Data=0xAAAAAAAA, several edges. Register 5 must stay 0.
  - Memory write with wea=0 at addr=20 must leave mem[20]=0.
- Reset does not clear memory: after the store above, apply Reset=0 for one edge (registers become 0), release, then set addr=13 for one edge. douta must equal 0xFFC7FF6F.
